// File: rtl/matmul_feed_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matmul_feed_ctrl_if
// Brief    : Request/feed bundle between a host and matmul_feed_ctrl.
//            master = host side (start, matrices), slave = the sequencer.
//            abort_i exists only when MATMUL_FEED_CTRL_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface matmul_feed_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32
);
    localparam int c_max_dim = BUS_WIDTH / DATA_WIDTH;
    localparam int c_mat_w   = c_max_dim * c_max_dim * DATA_WIDTH;

    logic                 start_i;
    logic [c_mat_w-1:0]   a_mat_i;
    logic [c_mat_w-1:0]   b_mat_i;
`ifdef MATMUL_FEED_CTRL_ABORT_EN
    logic                 abort_i;
`endif
    logic [BUS_WIDTH-1:0] a_vec_o;
    logic [BUS_WIDTH-1:0] b_vec_o;
    logic                 calc_clear_o;
    logic                 calc_start_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
`ifdef MATMUL_FEED_CTRL_ABORT_EN
        output abort_i,
`endif
        output start_i, a_mat_i, b_mat_i,
        input  a_vec_o, b_vec_o, calc_clear_o, calc_start_o, busy_o, done_o
    );

    modport slave (
`ifdef MATMUL_FEED_CTRL_ABORT_EN
        input  abort_i,
`endif
        input  start_i, a_mat_i, b_mat_i,
        output a_vec_o, b_vec_o, calc_clear_o, calc_start_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/matmul_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : matmul_feed_ctrl
// Brief    : Sequencer for the systolic matmul_calc datapath. Snapshots A/B on
//            start, feeds diagonally skewed A rows / B columns, appends zero
//            drain cycles, then pulses done. All outputs registered.
//            Optional abort input: define MATMUL_FEED_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_feed_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int DRAIN_CYCLES = BUS_WIDTH / DATA_WIDTH
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    matmul_feed_ctrl_if.slave bus
);
    localparam int c_max_dim      = BUS_WIDTH / DATA_WIDTH;
    localparam int c_mat_w        = c_max_dim * c_max_dim * DATA_WIDTH;
    localparam int c_array_length = 2 * c_max_dim - 1;
    localparam int c_t_w          = (c_array_length > 1) ? $clog2(c_array_length) : 1;
    localparam int c_d_w          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [c_t_w-1:0] c_t_last = c_t_w'(c_array_length - 1);
    localparam logic [c_t_w-1:0] c_t_one  = c_t_w'(1);
    localparam logic [c_d_w-1:0] c_d_last = c_d_w'(DRAIN_CYCLES - 1);
    localparam logic [c_d_w-1:0] c_d_one  = c_d_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_t_w-1:0]     r_t;
    logic [c_t_w-1:0]     w_t_next;
    logic [c_d_w-1:0]     r_d;
    logic [c_d_w-1:0]     w_d_next;
    logic                 w_latch;
    logic [c_mat_w-1:0]   r_a_snap;
    logic [c_mat_w-1:0]   r_b_snap;
    logic [BUS_WIDTH-1:0] w_a_vec_next;
    logic [BUS_WIDTH-1:0] w_b_vec_next;
    logic [BUS_WIDTH-1:0] r_a_vec;
    logic [BUS_WIDTH-1:0] r_b_vec;
    logic                 r_clear;
    logic                 r_cstart;
    logic                 r_busy;
    logic                 r_done;

    // Next-state and counter sequencing; start is only honoured in IDLE/DONE.
    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_d_next     = r_d;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_latch      = 1'b1;
                    w_t_next     = '0;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_t_next     = '0;
                w_state_next = S_FEED;
            end
            S_FEED: begin
                if (r_t == c_t_last) begin
                    w_d_next     = '0;
                    w_state_next = S_DRAIN;
                end else begin
                    w_t_next = r_t + c_t_one;
                end
            end
            S_DRAIN: begin
                if (r_d == c_d_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_d_next = r_d + c_d_one;
                end
            end
            S_DONE: begin
                if (bus.start_i) begin
                    w_latch      = 1'b1;
                    w_t_next     = '0;
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
`ifdef MATMUL_FEED_CTRL_ABORT_EN
        // Abort wins over everything while a sequence is in flight.
        if (bus.abort_i &&
            ((r_state == S_LOAD) || (r_state == S_FEED) || (r_state == S_DRAIN))) begin
            w_state_next = S_IDLE;
            w_t_next     = '0;
            w_d_next     = '0;
            w_latch      = 1'b0;
        end
`endif
    end

    // Skewed vectors for the upcoming FEED step: element (r,c) enters on step r+c,
    // on A lane r and B lane c; anything outside the diagonal band stays zero.
    always_comb begin
        w_a_vec_next = '0;
        w_b_vec_next = '0;
        if (w_state_next == S_FEED) begin
            for (int r = 0; r < c_max_dim; r++) begin
                for (int c = 0; c < c_max_dim; c++) begin
                    if (int'(w_t_next) == r + c) begin
                        w_a_vec_next[r*DATA_WIDTH +: DATA_WIDTH] =
                            r_a_snap[(r*c_max_dim + c)*DATA_WIDTH +: DATA_WIDTH];
                        w_b_vec_next[c*DATA_WIDTH +: DATA_WIDTH] =
                            r_b_snap[(r*c_max_dim + c)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // State, step counters and matrix snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_t      <= '0;
            r_d      <= '0;
            r_a_snap <= '0;
            r_b_snap <= '0;
        end else begin
            r_state <= w_state_next;
            r_t     <= w_t_next;
            r_d     <= w_d_next;
            if (w_latch) begin
                r_a_snap <= bus.a_mat_i;
                r_b_snap <= bus.b_mat_i;
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a_vec  <= '0;
            r_b_vec  <= '0;
            r_clear  <= 1'b0;
            r_cstart <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_a_vec  <= w_a_vec_next;
            r_b_vec  <= w_b_vec_next;
            r_clear  <= (w_state_next == S_LOAD);
            r_cstart <= (w_state_next == S_FEED) || (w_state_next == S_DRAIN) ||
                        (w_state_next == S_DONE);
            r_busy   <= (w_state_next == S_LOAD) || (w_state_next == S_FEED) ||
                        (w_state_next == S_DRAIN);
            r_done   <= (w_state_next == S_DONE);
        end
    end

    assign bus.a_vec_o      = r_a_vec;
    assign bus.b_vec_o      = r_b_vec;
    assign bus.calc_clear_o = r_clear;
    assign bus.calc_start_o = r_cstart;
    assign bus.busy_o       = r_busy;
    assign bus.done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matmul_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matmul_feed_ctrl
// Brief    : Self-checking bench for matmul_feed_ctrl (4x4, 8-bit elements).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_feed_ctrl;
    localparam int c_dw = 8;
    localparam int c_bw = 32;

    typedef struct packed {
        logic [31:0] a_vec;
        logic [31:0] b_vec;
        logic        clear;
        logic        cstart;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        logic [127:0] a_mat;
        logic [127:0] b_mat;
        exp_t         first_feed;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    vec_t tbl[4];

    matmul_feed_ctrl_if #(.DATA_WIDTH(c_dw), .BUS_WIDTH(c_bw)) bus ();

    matmul_feed_ctrl #(.DATA_WIDTH(c_dw), .BUS_WIDTH(c_bw)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        return {bus.a_vec_o, bus.b_vec_o, bus.calc_clear_o, bus.calc_start_o,
                bus.busy_o, bus.done_o};
    endfunction

    // Lane i carries A(i, t-i).
    function automatic logic [31:0] skew_a(input logic [127:0] m, input int t);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = t - i;
            if (k >= 0 && k < 4) v[i*8 +: 8] = m[(i*4 + k)*8 +: 8];
        end
        return v;
    endfunction

    // Lane j carries B(t-j, j).
    function automatic logic [31:0] skew_b(input logic [127:0] m, input int t);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            int r;
            r = t - j;
            if (r >= 0 && r < 4) v[j*8 +: 8] = m[(r*4 + j)*8 +: 8];
        end
        return v;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic push_run(input logic [127:0] a, input logic [127:0] b);
        sb_q.push_back('{a_vec: '0, b_vec: '0, clear: 1'b1, cstart: 1'b0, busy: 1'b1, done: 1'b0});
        for (int t = 0; t < 7; t++)
            sb_q.push_back('{a_vec: skew_a(a, t), b_vec: skew_b(b, t), clear: 1'b0,
                             cstart: 1'b1, busy: 1'b1, done: 1'b0});
        for (int d = 0; d < 4; d++)
            sb_q.push_back('{a_vec: '0, b_vec: '0, clear: 1'b0, cstart: 1'b1, busy: 1'b1, done: 1'b0});
        sb_q.push_back('{a_vec: '0, b_vec: '0, clear: 1'b0, cstart: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    task automatic push_idle();
        sb_q.push_back('0);
    endtask

    task automatic wait_sb();
        for (int n = 0; n < 200; n++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_timeout left=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic pulse_start(input logic [127:0] a, input logic [127:0] b);
        @(negedge clk);
        bus.a_mat_i = a;
        bus.b_mat_i = b;
        bus.start_i = 1'b1;
    endtask

    // Scoreboard consumer: one expected record per clock while any are pending.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_cycle", actual(), e);
        end
    end

    initial begin
        logic [127:0] m_spec;
        logic [127:0] m_id;
        int first_done;
        int n_done;
        checks = 0;
        errors = 0;
        m_spec = 128'h01020304_05060708_08070605_04030201;
        m_id   = '0;
        for (int i = 0; i < 4; i++) m_id[(i*4 + i)*8 +: 8] = 8'h01;

        tbl[0] = '{a_mat: m_spec, b_mat: m_spec,
                   first_feed: '{a_vec: 32'h00000001, b_vec: 32'h00000001, clear: 1'b0,
                                 cstart: 1'b1, busy: 1'b1, done: 1'b0}};
        tbl[1] = '{a_mat: m_id, b_mat: m_spec,
                   first_feed: '{a_vec: 32'h00000001, b_vec: 32'h00000001, clear: 1'b0,
                                 cstart: 1'b1, busy: 1'b1, done: 1'b0}};
        tbl[2] = '{a_mat: {128{1'b1}}, b_mat: 128'h100f0e0d_0c0b0a09_08070605_040302ff,
                   first_feed: '{a_vec: 32'h000000ff, b_vec: 32'h000000ff, clear: 1'b0,
                                 cstart: 1'b1, busy: 1'b1, done: 1'b0}};
        tbl[3] = '{a_mat: {$urandom, $urandom, $urandom, 32'h00000042},
                   b_mat: {$urandom, $urandom, $urandom, 32'h00000099},
                   first_feed: '{a_vec: 32'h00000042, b_vec: 32'h00000099, clear: 1'b0,
                                 cstart: 1'b1, busy: 1'b1, done: 1'b0}};

        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_mat_i = '0;
        bus.b_mat_i = '0;
`ifdef MATMUL_FEED_CTRL_ABORT_EN
        bus.abort_i = 1'b0;
`endif
        #13;
        check("reset_state", actual(), '0);
        @(negedge clk);
        rst = 1'b0;

        // Spec vectors, checked by hand at fixed points; matrices change after sampling.
        pulse_start(m_spec, m_spec);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_mat_i = '0;
        bus.b_mat_i = '0;
        check("load", actual(), '{a_vec: '0, b_vec: '0, clear: 1'b1, cstart: 1'b0, busy: 1'b1, done: 1'b0});
        @(negedge clk);
        check("feed_t0", actual(), '{a_vec: 32'h00000001, b_vec: 32'h00000001, clear: 1'b0,
                                     cstart: 1'b1, busy: 1'b1, done: 1'b0});
        @(negedge clk);
        check("feed_t1", actual(), '{a_vec: 32'h00000502, b_vec: 32'h00000205, clear: 1'b0,
                                     cstart: 1'b1, busy: 1'b1, done: 1'b0});
        repeat (5) @(negedge clk);
        check("feed_t6", actual(), '{a_vec: 32'h01000000, b_vec: 32'h01000000, clear: 1'b0,
                                     cstart: 1'b1, busy: 1'b1, done: 1'b0});
        first_done = 0;
        n_done     = 0;
        for (int n = 9; n <= 30; n++) begin
            @(negedge clk);
            if (bus.done_o) begin
                n_done++;
                if (first_done == 0) first_done = n - 1;
            end
        end
        checks++;
        if (first_done != 12) begin
            errors++;
            $display("FAIL done_latency got=%0d required=12", first_done);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL done_pulses got=%0d required=1", n_done);
        end

        // Table: each entry runs a full sequence through the scoreboard.
        for (int v = 0; v < 4; v++) begin
            pulse_start(tbl[v].a_mat, tbl[v].b_mat);
            push_run(tbl[v].a_mat, tbl[v].b_mat);
            push_idle();
            @(negedge clk);
            bus.start_i = 1'b0;
            @(negedge clk);
            check("table_first_feed", actual(), tbl[v].first_feed);
            wait_sb();
        end

        // start held high: ignored mid-run, re-latched in DONE with new matrices.
        pulse_start(tbl[0].a_mat, tbl[0].b_mat);
        push_run(tbl[0].a_mat, tbl[0].b_mat);
        push_run(tbl[2].a_mat, tbl[2].b_mat);
        push_idle();
        @(negedge clk);
        bus.a_mat_i = tbl[2].a_mat;
        bus.b_mat_i = tbl[2].b_mat;
        repeat (13) @(negedge clk);
        bus.start_i = 1'b0;
        wait_sb();

        // Asynchronous reset during FEED t=3, then a clean run.
        pulse_start(tbl[3].a_mat, tbl[3].b_mat);
        push_run(tbl[3].a_mat, tbl[3].b_mat);
        for (int k = 0; k < 8; k++) void'(sb_q.pop_back());
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", actual(), '0);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_records left=%0d required=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        rst = 1'b0;
        push_idle();
        wait_sb();
        pulse_start(tbl[1].a_mat, tbl[1].b_mat);
        push_run(tbl[1].a_mat, tbl[1].b_mat);
        push_idle();
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_sb();

`ifdef MATMUL_FEED_CTRL_ABORT_EN
        // Abort during the second DRAIN cycle: IDLE next edge, no done pulse.
        pulse_start(tbl[0].a_mat, tbl[0].b_mat);
        push_run(tbl[0].a_mat, tbl[0].b_mat);
        for (int k = 0; k < 3; k++) void'(sb_q.pop_back());
        push_idle();
        push_idle();
        push_idle();
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        wait_sb();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
